uart_tx_frame: RTL and testbench



---
 rtl/uart_tx_frame.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_frame.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: byte-serial 8N1 UART transmitter, LSB first.
//
// A level start request in IDLE latches the parallel byte and sends one
// frame: start bit, NB_DATA data bits, stop time of SB_TICKS ticks.
// An internal divider produces one oversample tick every BAUD_DIV clocks.
// N_TICKS ticks make one bit.
//
// Ports:
//   i_clk       system clock
//   i_rst       synchronous reset, active-high
//   i_tx_start  level request; sampled only in IDLE
//   i_data      byte to send; latched when a start is accepted
//   o_tx        serial line, idle high
//   o_tx_done   1 while the transmitter is free (IDLE or DONE)
//   o_busy      inverse of o_tx_done
module uart_tx_frame #(
    parameter int NB_DATA  = 8,
    parameter int BAUD_DIV = 163,
    parameter int N_TICKS  = 16,
    parameter int SB_TICKS = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_tx,
    output logic               o_tx_done,
    output logic               o_busy
);

    localparam int DIV_W     = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int MAX_TICKS = (N_TICKS > SB_TICKS) ? N_TICKS : SB_TICKS;
    localparam int TCK_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam int BIT_W     = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BAUD_DIV - 1);
    localparam logic [TCK_W-1:0] BIT_TLAST = TCK_W'(N_TICKS - 1);
    localparam logic [TCK_W-1:0] STP_TLAST = TCK_W'(SB_TICKS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(NB_DATA - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    logic [DIV_W-1:0]   r_div;
    logic [TCK_W-1:0]   r_tck;
    logic [BIT_W-1:0]   r_bit;
    logic [NB_DATA-1:0] r_shreg;
    logic               r_tx;
    logic               r_tx_done;
    logic               r_busy;

    logic               w_tick;
    logic [NB_DATA-1:0] w_shreg_next;

    // The divider is held at zero while free, so the first tick of a frame
    // lands exactly BAUD_DIV clocks after the accept edge.
    assign w_tick       = (r_div == DIV_LAST) && (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_shreg_next = r_shreg >> 1;

    assign o_tx      = r_tx;
    assign o_tx_done = r_tx_done;
    assign o_busy    = r_busy;

    // Frame FSM with tick divider, tick/bit counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_tck     <= '0;
            r_bit     <= '0;
            r_shreg   <= '0;
            r_tx      <= 1'b1;
            r_tx_done <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) || (r_state == S_DONE) || w_tick) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    r_tx      <= 1'b1;
                    r_tx_done <= 1'b1;
                    r_busy    <= 1'b0;
                    if (i_tx_start) begin
                        r_shreg   <= i_data;
                        r_tck     <= '0;
                        r_bit     <= '0;
                        r_tx      <= 1'b0;
                        r_tx_done <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_START;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_tck == BIT_TLAST) begin
                            r_tck   <= '0;
                            r_tx    <= r_shreg[0];
                            r_state <= S_DATA;
                        end else begin
                            r_tck <= r_tck + 1'b1;
                        end
                    end else begin
                        r_tck <= r_tck;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_tck == BIT_TLAST) begin
                            r_tck   <= '0;
                            r_shreg <= w_shreg_next;
                            if (r_bit == BIT_LAST) begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end else begin
                                // Drive the bit that becomes the LSB after this shift.
                                r_bit <= r_bit + 1'b1;
                                r_tx  <= w_shreg_next[0];
                            end
                        end else begin
                            r_tck <= r_tck + 1'b1;
                        end
                    end else begin
                        r_tck <= r_tck;
                    end
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_tick) begin
                        if (r_tck == STP_TLAST) begin
                            r_tck     <= '0;
                            r_tx_done <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= S_DONE;
                        end else begin
                            r_tck <= r_tck + 1'b1;
                        end
                    end else begin
                        r_tck <= r_tck;
                    end
                end
                S_DONE: begin
                    // One free cycle so the requester can present its next
                    // byte before the start request is sampled again.
                    r_tx      <= 1'b1;
                    r_tx_done <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_tx      <= 1'b1;
                    r_tx_done <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
module tb_uart_tx_frame;

    logic       i_clk;
    logic       i_rst;
    logic       i_tx_start;
    logic [7:0] i_data;
    logic       o_tx;
    logic       o_tx_done;
    logic       o_busy;

    int n_tests;
    int n_fail;

    uart_tx_frame #(
        .NB_DATA (8),
        .BAUD_DIV(2),
        .N_TICKS (16),
        .SB_TICKS(16)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_tx_start(i_tx_start),
        .i_data    (i_data),
        .o_tx      (o_tx),
        .o_tx_done (o_tx_done),
        .o_busy    (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Table record: byte and its hand-built line pattern, index 0 = start
    // bit, 1..8 = data LSB first, 9 = stop bit. One bit = 32 clocks.
    typedef struct {
        logic [7:0] data;
        logic [9:0] line;
    } vec_t;

    vec_t vecs[3];

    // Independent serial receiver: mid-bit sampling at 32 clocks per bit.
    logic [7:0] rx_q[$];
    int         rx_ferr;
    int         rises;

    initial begin : rx_model
        int         cnt;
        logic       active;
        logic [7:0] b;
        cnt = 0; active = 1'b0; b = 8'h00; rx_ferr = 0;
        forever begin
            @(negedge i_clk);
            if (!active) begin
                if (o_tx === 1'b0) begin
                    active = 1'b1;
                    cnt = 0;
                end
            end else begin
                cnt++;
                if ((o_tx_done === 1'b1) && (cnt < 304)) begin
                    active = 1'b0;
                end else if (cnt == 16) begin
                    if (o_tx !== 1'b0) rx_ferr++;
                end else if ((cnt >= 48) && (cnt <= 272) && (((cnt - 48) % 32) == 0)) begin
                    b[(cnt - 48) / 32] = o_tx;
                end else if (cnt == 304) begin
                    if (o_tx !== 1'b1) rx_ferr++;
                    else rx_q.push_back(b);
                    active = 1'b0;
                end
            end
        end
    end

    initial begin : rise_counter
        logic prev;
        prev = 1'b1;
        rises = 0;
        forever begin
            @(negedge i_clk);
            if ((o_tx_done === 1'b1) && (prev === 1'b0)) rises++;
            prev = o_tx_done;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Request a frame at the next edge; returns just after the accept edge.
    task automatic accept(input logic [7:0] d);
        @(negedge i_clk);
        i_tx_start = 1'b1;
        i_data     = d;
        @(posedge i_clk);
    endtask

    // Checks one frame cycle by cycle from the accept edge to o_tx_done
    // rising 320 clocks later; one comparison per bit period.
    task automatic check_frame(input logic [9:0] line, input int drop_at,
                               input int chg_at, input logic [7:0] new_data,
                               input string tag);
        logic ok;
        int   c;
        for (int b = 0; b < 10; b++) begin
            ok = 1'b1;
            for (int j = 0; j < 32; j++) begin
                @(negedge i_clk);
                c = b * 32 + j;
                if ((o_tx !== line[b]) || (o_tx_done !== 1'b0) || (o_busy !== 1'b1)) ok = 1'b0;
                if (c == drop_at) i_tx_start = 1'b0;
                if (c == chg_at) i_data = new_data;
            end
            chk($sformatf("%s_bit%0d", tag, b), {31'd0, ok}, 32'd1);
        end
        @(negedge i_clk);
        chk({tag, "_done_at_320"}, {29'd0, o_tx, o_tx_done, o_busy}, 32'd6);
    endtask

    initial begin : main
        logic [7:0] bytes[4];
        int         lows;
        int         done_lows;
        int         r0;
        int         idx;
        logic       prev;

        n_tests = 0;
        n_fail  = 0;
        vecs[0] = '{data: 8'hA5, line: 10'h34A};
        vecs[1] = '{data: 8'h81, line: 10'h302};
        vecs[2] = '{data: 8'h5A, line: 10'h2B4};
        bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56; bytes[3] = 8'h07;

        // Reset state
        i_rst = 1'b1; i_tx_start = 1'b0; i_data = 8'h00;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("reset_tx", {31'd0, o_tx}, 32'd1);
        chk("reset_done", {31'd0, o_tx_done}, 32'd1);
        chk("reset_busy", {31'd0, o_busy}, 32'd0);
        i_rst = 1'b0;

        // Idle with no request: line stays high
        lows = 0; done_lows = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge i_clk);
            if (o_tx !== 1'b1) lows++;
            if (o_tx_done !== 1'b1) done_lows++;
        end
        chk("idle_tx_low_count", lows, 32'd0);
        chk("idle_done_low_count", done_lows, 32'd0);

        // Table-driven single-pulse frames
        for (int v = 0; v < 3; v++) begin
            rx_q.delete();
            r0 = rises;
            accept(vecs[v].data);
            check_frame(vecs[v].line, 0, -1, 8'h00, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d_rises", v), rises - r0, 32'd1);
            chk($sformatf("vec%0d_rx_count", v), rx_q.size(), 32'd1);
            if (rx_q.size() > 0) chk($sformatf("vec%0d_rx_byte", v), {24'd0, rx_q[0]}, {24'd0, vecs[v].data});
            repeat (4) @(negedge i_clk);
        end

        // Back-to-back with start held; data changes mid-frame
        rx_q.delete();
        r0 = rises;
        accept(8'h3C);
        check_frame(10'h278, -1, 160, 8'hFF, "b2b_first");
        @(negedge i_clk);
        chk("b2b_gap_idle", {30'd0, o_tx, o_tx_done}, 32'd3);
        check_frame(10'h3FE, 0, -1, 8'h00, "b2b_second");
        chk("b2b_rises", rises - r0, 32'd2);
        chk("b2b_rx_count", rx_q.size(), 32'd2);
        if (rx_q.size() == 2) begin
            chk("b2b_rx_first", {24'd0, rx_q[0]}, 32'h3C);
            chk("b2b_rx_second", {24'd0, rx_q[1]}, 32'hFF);
        end
        repeat (4) @(negedge i_clk);

        // Start asserted only during the DONE cycle is ignored
        accept(8'h66);
        check_frame(10'h2CC, 0, -1, 8'h00, "donepoke");
        i_tx_start = 1'b1;
        @(negedge i_clk);
        i_tx_start = 1'b0;
        lows = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge i_clk);
            if ((o_tx !== 1'b1) || (o_tx_done !== 1'b1)) lows++;
        end
        chk("donepoke_no_frame", lows, 32'd0);

        // Reset during data bit 4 aborts; next frame is clean
        rx_q.delete();
        accept(8'h0F);
        for (int c = 0; c <= 170; c++) begin
            @(negedge i_clk);
            if (c == 0) i_tx_start = 1'b0;
        end
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("abort_outputs", {29'd0, o_tx, o_tx_done, o_busy}, 32'd6);
        i_rst = 1'b0;
        repeat (3) @(negedge i_clk);
        accept(8'h81);
        check_frame(10'h302, 0, -1, 8'h00, "after_abort");
        chk("after_abort_rx_count", rx_q.size(), 32'd1);
        if (rx_q.size() > 0) chk("after_abort_rx_byte", {24'd0, rx_q[0]}, 32'h81);
        repeat (4) @(negedge i_clk);

        // Host-interface model: advance on each o_tx_done rising edge
        rx_q.delete();
        r0 = rises;
        idx = 0;
        @(negedge i_clk);
        i_data = bytes[0];
        i_tx_start = 1'b1;
        prev = 1'b1;
        for (int c = 0; (c < 2000) && (idx < 4); c++) begin
            @(negedge i_clk);
            if ((o_tx_done === 1'b1) && (prev === 1'b0)) begin
                idx++;
                if (idx < 4) i_data = bytes[idx];
                else i_tx_start = 1'b0;
            end
            prev = o_tx_done;
        end
        i_tx_start = 1'b0;
        chk("host_bytes_done", idx, 32'd4);
        repeat (10) @(negedge i_clk);
        chk("host_rises", rises - r0, 32'd4);
        chk("host_rx_count", rx_q.size(), 32'd4);
        if (rx_q.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("host_rx_%0d", k), {24'd0, rx_q[k]}, {24'd0, bytes[k]});
            end
        end
        chk("rx_framing_errors", rx_ferr, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
